// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: 2R/2W bypassed register file with sweep clear and load-use scoreboard
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              hazard_a,
  output logic              hazard_b
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] sb;
  logic idle, wr_ok, wr0_ok, wr1_ok, sb_ok;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= SWEEP;
    else state <= state_nxt;

  always_comb
    state_nxt = (state == SWEEP) ? ((&ptr) ? IDLE : SWEEP) : (clear_req ? SWEEP : IDLE);

  always_comb begin
    clear_busy = state == SWEEP;
    idle       = state == IDLE;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) ptr <= '0;
    else if (clear_busy) ptr <= ptr + 1'b1;
    else if (clear_req) ptr <= '0;

  // a clear request in IDLE drops the writes of the same cycle
  assign wr_ok  = idle && !clear_req;
  assign wr0_ok = wr_ok && wr0_en && !is_zero(wr0_addr);
  assign wr1_ok = wr_ok && wr1_en && !is_zero(wr1_addr);
  assign sb_ok  = sb_set && !is_zero(sb_addr);

  // wr1 is applied last so it wins on an address collision
  always_ff @(posedge clock)
    if (clear_busy) mem[ptr] <= '0;
    else begin
      if (wr0_ok) mem[wr0_addr] <= wr0_data;
      if (wr1_ok) mem[wr1_addr] <= wr1_data;
    end

  // the new load wins over a same-cycle writeback to the same register
  always_ff @(posedge clock or negedge reset)
    if (!reset) sb <= '0;
    else if (idle && clear_req) sb <= '0;
    else if (idle) begin
      if (wr0_en) sb[wr0_addr] <= 1'b0;
      if (sb_ok) sb[sb_addr] <= 1'b1;
    end

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return (!idle || is_zero(a)) ? '0
         : (wr1_en && wr1_addr == a) ? wr1_data
         : (wr0_en && wr0_addr == a) ? wr0_data
         : mem[a];
  endfunction

  function automatic logic hz(input logic [ADDR_W-1:0] a);
    return idle && sb[a] && !(wr0_en && wr0_addr == a);
  endfunction

  always_comb begin
    rd_data_a = rd(rd_addr_a);
    rd_data_b = rd(rd_addr_b);
    hazard_a  = hz(rd_addr_a);
    hazard_b  = hz(rd_addr_b);
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the decode-stage register file for the pipelined MIPS core.
- Provides two bypassed combinational read ports and two synchronous write ports: port 0 carries ALU/memory writeback, port 1 carries the jal link.
- Adds a multi-cycle clear sequencer in place of a single-cycle mass reset.
- Adds a per-register pending-load scoreboard that flags load-use hazards to the hazard unit.

Parameters:
- DATA_W, 32, width of each register.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never scoreboarded.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear_req  in  1  pulse: start a full clear sweep.
- clear_busy  out  1  high while the sweep runs.
- rd_addr_a  in  ADDR_W  read port A address (rs).
- rd_data_a  out  DATA_W  read port A data.
- rd_addr_b  in  ADDR_W  read port B address (rt).
- rd_data_b  out  DATA_W  read port B data.
- wr0_en  in  1  writeback write enable.
- wr0_addr  in  ADDR_W  writeback destination.
- wr0_data  in  DATA_W  writeback data.
- wr1_en  in  1  link write enable.
- wr1_addr  in  ADDR_W  link destination (normally 31).
- wr1_data  in  DATA_W  link data (pc+4).
- sb_set  in  1  mark sb_addr as awaiting a load.
- sb_addr  in  ADDR_W  load destination to mark.
- hazard_a  out  1  port A register pending a load.
- hazard_b  out  1  port B register pending a load.

Behaviour:
- Reset (async, reset=0):
  - state<=SWEEP, sweep pointer<=0, all scoreboard bits<=0.
  - Storage array is not reset directly.
  - Outputs during and after reset: clear_busy=1; rd_data_a/b=0; hazard_a/b=0.
- State SWEEP:
  - Each clock writes 0 to entry[ptr], then ptr<=ptr+1.
  - After entry DEPTH-1 is written, go to IDLE; clear_busy falls the following cycle. Sweep length is exactly DEPTH cycles after reset release.
  - wr0/wr1/sb_set are ignored.
  - Reads return 0 and hazards are 0.
  - clear_req is ignored.
- State IDLE:
  - clear_req=1 → SWEEP with ptr<=0. The scoreboard is cleared on the same edge.
  - Writes take effect on the same edge as clear_req are dropped.
- Writes (IDLE only), on the rising edge:
  - wr0_en writes wr0_data to wr0_addr; wr1_en writes wr1_data to wr1_addr.
  - Both enabled with the same address: wr1 wins.
  - If ZERO_REG=1, writes to address 0 are discarded.
- Reads are combinational with write-first bypass:
  - If wr1_en and wr1_addr==rd_addr, return wr1_data.
  - Else if wr0_en and wr0_addr==rd_addr, return wr0_data.
  - Else return the stored value.
  - Address 0 with ZERO_REG=1 returns 0 regardless of bypass.
  - Port A and port B are independent.
- Scoreboard, one bit per register:
  - sb_set sets bit[sb_addr].
  - wr0_en clears bit[wr0_addr]. wr1 does not touch the scoreboard.
  - sb_set and wr0_en to the same address in the same cycle: the bit ends set, because the new load wins.
  - sb_set to address 0 is ignored when ZERO_REG=1.
- Hazard outputs:
  - hazard_x = bit[rd_addr_x] AND NOT (wr0_en AND wr0_addr==rd_addr_x). A same-cycle writeback resolves the hazard through the bypass.
  - Both hazards are forced to 0 in SWEEP.
- Latency:
  - Write to visible-in-storage: 1 cycle. Bypass makes data visible in the same cycle.
  - sb_set to hazard visible: 1 cycle.
- Reset asserted mid-sweep or mid-operation restarts the sweep from ptr=0.

Test Plan:
1. Release reset → clear_busy=1 for exactly 32 cycles (ADDR_W=5), then 0. Every register reads 0. A wr0 to reg 5 during the sweep is lost; reading reg 5 afterwards gives 0.
2. IDLE, wr0 reg 8 = 0xDEADBEEF, with rd_addr_a=8 in the same cycle → rd_data_a=0xDEADBEEF combinationally, and still 0xDEADBEEF the next cycle with wr0_en=0.
3. Same cycle: wr0 reg 31=0x11111111 and wr1 reg 31=0x00400008 → bypass and stored value are both 0x00400008. Write reg 0 = 0xFFFFFFFF → reads 0.
4. sb_set reg 9, then rd_addr_b=9 next cycle → hazard_b=1. Cycle with wr0 reg 9 = 0x1234 → hazard_b=0 and rd_data_b=0x1234. Next cycle → hazard_b=0.
5. sb_set reg 9 and wr0 reg 9 in the same cycle → hazard on reg 9 is 1 the next cycle.
6. Load regs 1..3 with nonzero values and set the scoreboard on reg 4. Pulse clear_req → 32 busy cycles, then all reads are 0 and hazards are 0. Assert reset at sweep cycle 10 → busy restarts a full 32-cycle sweep.
